// File: rtl/gpu_rf_access_ctrl.sv
// Request-side controller for the GPU register file: single-beat writes,
// wrap-around burst reads with range checking, valid/ready on both channels.
module gpu_rf_access_ctrl #(
    parameter int D_WIDTH  = 16,
    parameter int A_WIDTH  = 4,
    parameter int RF_DEPTH = 4,
    parameter int L_WIDTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    input  logic [L_WIDTH-1:0] req_len,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic               rsp_err,
    output logic               rsp_last,
    output logic [D_WIDTH-1:0] rf_write_data,
    output logic [A_WIDTH-1:0] rf_write_addr,
    output logic               rf_write_enable,
    output logic [A_WIDTH-1:0] rf_read_addr,
    input  logic [D_WIDTH-1:0] rf_read_data
);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_RESP} state_t;

    localparam logic [A_WIDTH:0]   DEPTH     = (A_WIDTH+1)'(RF_DEPTH);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(RF_DEPTH - 1);

    state_t             state;
    state_t             state_next;
    logic [A_WIDTH-1:0] cur_addr;
    logic [L_WIDTH-1:0] remaining;
    logic               req_fire;
    logic               rsp_fire;
    logic               req_in_range;

    assign req_ready    = (state == IDLE);
    assign req_fire     = req_valid && req_ready;
    assign rsp_fire     = rsp_valid && rsp_ready;
    assign req_in_range = ({1'b0, req_addr} < DEPTH);
    assign rf_read_addr = (state == RD_ISSUE) ? cur_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Out-of-range writes still pass through WR so every write costs two cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_write) begin
                        state_next = WR;
                    end else if (req_in_range) begin
                        state_next = RD_ISSUE;
                    end else begin
                        state_next = RD_RESP;
                    end
                end
            end
            WR:       state_next = IDLE;
            RD_ISSUE: state_next = RD_RESP;
            RD_RESP: begin
                if (rsp_fire) begin
                    state_next = rsp_last ? IDLE : RD_ISSUE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            rsp_valid       <= 1'b0;
            rsp_err         <= 1'b0;
            rsp_last        <= 1'b0;
            rsp_data        <= '0;
            cur_addr        <= '0;
            remaining       <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (req_write) begin
                            if (req_in_range) begin
                                rf_write_enable <= 1'b1;
                                rf_write_addr   <= req_addr;
                                rf_write_data   <= req_wdata;
                            end
                        end else begin
                            cur_addr  <= req_addr;
                            remaining <= req_len;
                            if (!req_in_range) begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_last  <= 1'b1;
                                rsp_data  <= '0;
                            end
                        end
                    end
                end
                RD_ISSUE: begin
                    rsp_data  <= rf_read_data;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_last  <= (remaining == '0);
                end
                RD_RESP: begin
                    // Address wraps at the implemented depth, not at 2^A_WIDTH.
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        if (!rsp_last) begin
                            cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + A_WIDTH'(1);
                            remaining <= remaining - L_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_rf_access_ctrl.sv
// Scoreboard bench for gpu_rf_access_ctrl: directed scenarios plus randomized
// traffic checked against a register-array reference model.
module tb_gpu_rf_access_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [LW-1:0] req_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_last;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] rf_write_addr;
    logic          rf_write_enable;
    logic [AW-1:0] rf_read_addr;
    logic [DW-1:0] rf_read_data;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          last;
        logic [AW-1:0] addr;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    beat_t         expq[$];
    wr_t           wq[$];
    logic [DW-1:0] modelRegs [DEPTH];
    logic [DW-1:0] rfMem [DEPTH];

    int checks    = 0;
    int failures  = 0;
    int beatsSeen = 0;
    bit monitorOn   = 1'b0;
    bit randomReady = 1'b0;
    bit forceLow    = 1'b0;

    logic          prevValid = 1'b0;
    logic          prevReady = 1'b0;
    logic          prevRst   = 1'b0;
    logic [DW-1:0] prevData  = '0;
    logic          prevErr   = 1'b0;
    logic          prevLast  = 1'b0;
    logic [AW-1:0] prevReadAddr = '0;

    gpu_rf_access_ctrl #(
        .D_WIDTH(DW), .A_WIDTH(AW), .RF_DEPTH(DEPTH), .L_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .rf_write_data(rf_write_data), .rf_write_addr(rf_write_addr),
        .rf_write_enable(rf_write_enable), .rf_read_addr(rf_read_addr),
        .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file stand-in: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_write_enable && rf_write_addr < AW'(DEPTH)) begin
            rfMem[rf_write_addr[1:0]] <= rf_write_data;
        end
    end
    assign rf_read_data = (rf_read_addr < AW'(DEPTH)) ? rfMem[rf_read_addr[1:0]] : 16'hDEAD;

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (forceLow) begin
                rsp_ready = 1'b0;
            end else if (randomReady) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: event occurred, expected none at %0t", name, $time);
    endtask

    // Expected beats come straight from the register model with modular addressing.
    task automatic pushBurst(input logic [AW-1:0] base, input logic [LW-1:0] len);
        beat_t b;
        int    a;
        if (int'(base) >= DEPTH) begin
            b.data = '0; b.err = 1'b1; b.last = 1'b1; b.addr = base;
            expq.push_back(b);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                a      = (int'(base) + i) % DEPTH;
                b.data = modelRegs[a];
                b.err  = 1'b0;
                b.last = (i == int'(len));
                b.addr = AW'(a);
                expq.push_back(b);
            end
        end
    endtask

    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [LW-1:0] len);
        int  waitCycles;
        bit  accepted;
        wr_t w;
        waitCycles = 0;
        accepted   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_len = len;
        while (!accepted && waitCycles < 500) begin
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
            else waitCycles++;
        end
        if (!accepted) begin
            reportFail("req_accept_timeout");
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (wr) begin
                if (int'(addr) < DEPTH) begin
                    modelRegs[addr[1:0]] = data;
                    w.addr = addr;
                    w.data = data;
                    wq.push_back(w);
                end
            end else begin
                pushBurst(addr, len);
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(expq.size() == 0 && wq.size() == 0 && req_ready) && n < 3000);
        if (n >= 3000) reportFail("idle_timeout");
    endtask

    // Monitor: pops expectations on every handshake and write pulse.
    always @(negedge clk) begin
        beat_t b;
        wr_t   w;
        if (monitorOn) begin
            if (rsp_valid) checkOutput("ready_while_busy", 32'(req_ready), 32'd0);
            if (prevValid && !prevReady && !prevRst) begin
                checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
                checkOutput("hold_data", 32'(rsp_data), 32'(prevData));
                checkOutput("hold_err", 32'(rsp_err), 32'(prevErr));
                checkOutput("hold_last", 32'(rsp_last), 32'(prevLast));
            end
            if (rsp_valid && !prevValid && !prevRst && expq.size() > 0) begin
                if (!expq[0].err) checkOutput("rf_read_addr", 32'(prevReadAddr), 32'(expq[0].addr));
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    reportFail("unexpected_beat");
                end else begin
                    b = expq.pop_front();
                    checkOutput("rsp_data", 32'(rsp_data), 32'(b.data));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(b.err));
                    checkOutput("rsp_last", 32'(rsp_last), 32'(b.last));
                    beatsSeen++;
                end
            end
            if (rf_write_enable) begin
                if (wq.size() == 0) begin
                    reportFail("unexpected_write");
                end else begin
                    w = wq.pop_front();
                    checkOutput("wr_addr", 32'(rf_write_addr), 32'(w.addr));
                    checkOutput("wr_data", 32'(rf_write_data), 32'(w.data));
                end
            end
        end
        prevValid    <= rsp_valid;
        prevReady    <= rsp_ready;
        prevRst      <= rst;
        prevData     <= rsp_data;
        prevErr      <= rsp_err;
        prevLast     <= rsp_last;
        prevReadAddr <= rf_read_addr;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            n;
        int            start;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [LW-1:0] l;

        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 4'd1; req_wdata = 16'h1234; req_len = '0;
        @(posedge clk);
        #1;
        monitorOn = 1'b1;
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_last", 32'(rsp_last), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_wr_en", 32'(rf_write_enable), 32'd0);
        checkOutput("rst_wr_addr", 32'(rf_write_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(rf_write_data), 32'd0);
        checkOutput("rst_rd_addr", 32'(rf_read_addr), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst2_wr_en", 32'(rf_write_enable), 32'd0);
        checkOutput("rst2_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;

        $display("[TB] write then read-back");
        applyStimulus(1'b1, 4'd2, 16'hBEEF, '0);
        @(negedge clk);
        checkOutput("wr_busy_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("wr_ready_again", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 4'd2, '0, '0);
        @(negedge clk);
        checkOutput("rd_lat_cycle1_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rd_lat_cycle1_addr", 32'(rf_read_addr), 32'd2);
        @(negedge clk);
        checkOutput("rd_lat_cycle2_valid", 32'(rsp_valid), 32'd1);
        waitIdle();

        $display("[TB] wrap burst");
        applyStimulus(1'b1, 4'd0, 16'h0011, '0);
        applyStimulus(1'b1, 4'd1, 16'h0022, '0);
        applyStimulus(1'b1, 4'd2, 16'h0033, '0);
        applyStimulus(1'b1, 4'd3, 16'h0044, '0);
        applyStimulus(1'b0, 4'd3, '0, 4'd4);
        waitIdle();

        $display("[TB] backpressure");
        start = beatsSeen;
        applyStimulus(1'b0, 4'd3, '0, 4'd4);
        n = 0;
        while (beatsSeen < start + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) reportFail("bp_wait_timeout");
        forceLow = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        forceLow = 1'b0;
        waitIdle();
        checkOutput("bp_beats", 32'(beatsSeen - start), 32'd5);

        $display("[TB] out-of-range");
        applyStimulus(1'b1, 4'd7, 16'd5, '0);
        waitIdle();
        start = beatsSeen;
        applyStimulus(1'b0, 4'd5, '0, 4'd3);
        waitIdle();
        checkOutput("oor_beats", 32'(beatsSeen - start), 32'd1);

        $display("[TB] reset mid-burst");
        start = beatsSeen;
        applyStimulus(1'b0, 4'd0, '0, 4'd7);
        n = 0;
        while (beatsSeen < start + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) reportFail("rst_wait_timeout");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        wq.delete();
        repeat (4) begin
            @(negedge clk);
            checkOutput("rst_burst_valid", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 4'd1, '0, '0);
        waitIdle();

        $display("[TB] random traffic");
        randomReady = 1'b1;
        for (int t = 0; t < 60; t++) begin
            wr = ($urandom_range(0, 9) < 4);
            a  = ($urandom_range(0, 9) == 0) ? 4'd15 : AW'($urandom_range(0, 5));
            d  = DW'($urandom);
            l  = LW'($urandom_range(0, 15));
            applyStimulus(wr, a, d, l);
        end
        waitIdle();
        randomReady = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpu_rf_access_ctrl.md
Name: gpu_rf_access_ctrl

Overview:
- Initiator-side controller for the GPU register file.
- Accepts single-beat write commands and burst read commands on a valid/ready request channel.
- Drives the register file's write port (registered, one-cycle write pulse) and combinational read port.
- Returns read data on a valid/ready response channel, with range checking and wrap-around bursts.

Parameters:
- D_WIDTH, 16, register data width.
- A_WIDTH, 4, register address width.
- RF_DEPTH, 4, number of implemented registers. Valid addresses are 0..RF_DEPTH-1; RF_DEPTH <= 2^A_WIDTH.
- L_WIDTH, 4, burst length field width. A burst carries req_len+1 beats.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts request this cycle.
- req_write  input  1  1 = write, 0 = burst read.
- req_addr  input  A_WIDTH  write address, or read base address.
- req_wdata  input  D_WIDTH  write data.
- req_len  input  L_WIDTH  read beats minus 1; ignored for writes.
- rsp_valid  output  1  response beat present.
- rsp_ready  input  1  consumer accepts beat.
- rsp_data  output  D_WIDTH  read data.
- rsp_err  output  1  beat is an out-of-range error beat.
- rsp_last  output  1  final beat of burst.
- rf_write_data  output  D_WIDTH  to register file write_data.
- rf_write_addr  output  A_WIDTH  to register file write_addr.
- rf_write_enable  output  1  to register file write_enable.
- rf_read_addr  output  A_WIDTH  to register file read_addr.
- rf_read_data  input  D_WIDTH  from register file read_data; combinational from rf_read_addr.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE.
  - req_ready=1 (combinational from IDLE).
  - rsp_valid, rsp_err, rsp_last, rf_write_enable all 0.
  - rsp_data, rf_write_data, rf_write_addr, rf_read_addr all 0.
  - Reset mid-burst abandons the burst. No further beats are issued.
- States: IDLE, WR, RD_ISSUE, RD_RESP. req_ready=1 only in IDLE.
- IDLE, handshake with req_write=1:
  - If req_addr < RF_DEPTH: next cycle rf_write_enable=1 with the registered addr/data, then -> WR.
  - If out of range: the write is dropped silently (no enable, no response) -> WR.
- WR: lasts one cycle; rf_write_enable returns to 0; -> IDLE.
  - This bubble guarantees any following read sees the new value.
  - Write-to-write throughput is one per 2 cycles.
- IDLE, handshake with req_write=0:
  - Latch cur_addr=req_addr and remaining=req_len.
  - If req_addr >= RF_DEPTH: load error beat (rsp_data=0, rsp_err=1, rsp_last=1, rsp_valid=1) -> RD_RESP. req_len is ignored.
  - Otherwise -> RD_ISSUE.
- RD_ISSUE:
  - rf_read_addr=cur_addr.
  - At the clock edge, capture rf_read_data into rsp_data; set rsp_valid=1, rsp_err=0, rsp_last=(remaining==0).
  - -> RD_RESP.
- RD_RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready, clear rsp_valid.
  - If rsp_last: -> IDLE.
  - Else: cur_addr = (cur_addr==RF_DEPTH-1) ? 0 : cur_addr+1, remaining -= 1, -> RD_ISSUE.
- Read timing:
  - Latency from request accept to first rsp_valid: 2 cycles.
  - Beat rate with rsp_ready held at 1: one beat per 2 cycles.
- Bursts longer than RF_DEPTH wrap and re-read registers. Example: len=2^L_WIDTH-1 yields 16 beats.
- rsp_ready asserted while rsp_valid=0 has no effect.
- req_valid while busy is not consumed. Request fields must stay stable until the handshake.

Test Plan:
- Reset check: assert rst 2 cycles with req_valid=1 -> all outputs 0, req_ready=1, no rf_write_enable pulse.
- Write then read-back: write addr 2, data 16'hBEEF; then read addr 2 len 0 -> one rf_write_enable pulse (addr 2, data BEEF), request ready again 2 cycles later; response beat data BEEF, err=0, last=1, 2 cycles after accept.
- Wrap burst: preload regs 0..3 = 11,22,33,44; read base 3, len 4 -> beats 44,11,22,33,44; rsp_last only on the 5th beat; rf_read_addr sequence 3,0,1,2,3.
- Backpressure: same burst with rsp_ready low for 3 cycles on beat 2 -> rsp_data/rsp_last held stable; no beat lost or duplicated; req_ready=0 throughout.
- Out-of-range: write addr 7 data 5 -> no rf_write_enable. Read addr 5 len 3 -> exactly one beat: data 0, err=1, last=1; then IDLE.
- Reset mid-burst: read base 0 len 7; assert rst after beat 2 -> rsp_valid drops next cycle and stays 0; a new read addr 1 len 0 then completes normally.
